// File: rtl/output_serializer.sv
// output_serializer: buffers one result word and shifts it out MSB-first on each frame sync.
module output_serializer #(
  parameter int WIDTH = 40,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] result_in,
  input  logic             frame,
  output logic             sdout,
  output logic             out_ready,
  output logic             hold_valid,
  output logic             overrun,
  output logic             underrun,
  output logic             frame_err
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d, shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sdout_q, sdout_d, tx_q, tx_d, hv_q, hv_d;
  logic             ovr_q, ovr_d, und_q, und_d, ferr_q, ferr_d;
  logic             at_end, xfer;
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      sdout_q <= 1'b0;
      tx_q    <= 1'b0;
      hv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      und_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sdout_q <= sdout_d;
      tx_q    <= tx_d;
      hv_q    <= hv_d;
      ovr_q   <= ovr_d;
      und_q   <= und_d;
      ferr_q  <= ferr_d;
    end
  end
  // A frame is only honoured in IDLE or while the LSB is on the pin.
  always_comb begin
    at_end  = (state_q == IDLE) || (cnt_q == '0);
    xfer    = frame && at_end && hv_q;
    state_d = xfer ? SHIFT : (at_end ? IDLE : SHIFT);
    shift_d = xfer ? hold_q : (at_end ? '0 : shift_q << 1);
    cnt_d   = xfer ? CNT_W'(WIDTH - 1) : (at_end ? '0 : cnt_q - CNT_W'(1));
    tx_d    = xfer || !at_end;
    sdout_d = tx_d && shift_d[WIDTH-1];
    hold_d  = load ? result_in : hold_q;
    hv_d    = load || (hv_q && !xfer);
    ovr_d   = ovr_q || (load && hv_q && !xfer);
    und_d   = und_q || (frame && at_end && !hv_q);
    ferr_d  = ferr_q || (frame && !at_end);
  end
  assign sdout      = sdout_q;
  assign out_ready  = tx_q;
  assign hold_valid = hv_q;
  assign overrun    = ovr_q;
  assign underrun   = und_q;
  assign frame_err  = ferr_q;
endmodule

// File: doc/output_serializer.md
# output_serializer

Parallel-to-serial transmitter for the MSDAP output path. Accepts a 40-bit accumulator result on a one-cycle load strobe and buffers it in a one-deep holding register. On each frame sync it shifts the buffered word out MSB-first, one bit per clock. It sits between the ALU result/output-enable pair and the chip's serial output pin, and is the transmit end of the result interface.

## Interface
- `WIDTH`, 40, result word width; the serial frame length in bits.
- `CNT_W`, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

- `clk` input 1: system clock (SCLK); all state changes on rising edge.
- `clear_n` input 1: **reset, asynchronous, active-low**; one clock domain only.
- `load` input 1: one-cycle strobe; `result_in` is valid this cycle (driven by the ALU output enable).
- `result_in` input WIDTH: two's-complement result word.
- `frame` input 1: frame sync pulse; starts transmission of the held word.
- `sdout` output 1: serial data, MSB first.
- `out_ready` output 1: high on every cycle `sdout` carries a valid bit.
- `hold_valid` output 1: holding register contains an untransmitted word.
- `overrun` output 1: sticky; a held word was overwritten before being sent.
- `underrun` output 1: sticky; `frame` arrived with nothing held.
- `frame_err` output 1: sticky; `frame` arrived mid-transmission.

## Operation
- **Reset** (`clear_n`=0, async) sets all outputs and registers to 0: `sdout`, `out_ready`, `hold_valid`, `overrun`, `underrun`, `frame_err`, the shift register and the bit counter. The FSM goes to IDLE. Reset mid-word aborts the word immediately; no remaining bits are sent. Sticky flags clear only on reset.
- **Holding register:**
  - `load`=1 writes `result_in` and sets `hold_valid`.
  - If `load`=1 while `hold_valid`=1 and that word is not being transferred this cycle, the old word is lost, the new word is kept, and `overrun` is set.
- **FSM states:** IDLE and SHIFT.
  - IDLE, `frame`=1, `hold_valid`=1: copy holding to shift register, clear `hold_valid` (unless `load` the same cycle), counter = WIDTH-1, go to SHIFT.
  - IDLE, `frame`=1, `hold_valid`=0: set `underrun`, stay in IDLE. A `load` in the same cycle is held and is not sent.
  - SHIFT: each cycle, shift left by one and decrement the counter.
    - At counter 0 with no `frame`: return to IDLE.
    - At counter 0 with `frame`: this is a legal back-to-back frame and follows the IDLE `frame` rules (transfer or underrun), with no gap between words.
  - SHIFT, `frame`=1, counter ≠ 0: ignore the frame, set `frame_err`, and continue the current word.
- **Simultaneous `load` and transfer:** the transfer takes the old holding contents, the new word enters holding, and `hold_valid` stays 1. `overrun` is not set.
- **Data path:** the shift register is WIDTH bits. `sdout` = shift_reg[WIDTH-1] registered, `out_ready` is registered, and no arithmetic is applied to the data (bit-exact copy of `result_in`).

## Timing
- `frame` sampled high at edge E (valid transfer):
  - bit WIDTH-1 appears on `sdout` after E and is valid for cycle E+1.
  - bit i is valid in cycle E+1+(WIDTH-1-i).
  - the LSB is valid in cycle E+WIDTH.
- `out_ready` is 1 for exactly WIDTH cycles (E+1 through E+WIDTH) per transferred word, and 0 otherwise.
- Outside transmission, `sdout` = 0.
- Minimum legal frame spacing is WIDTH cycles. A `frame` in cycle E+WIDTH gives seamless continuation.
- `load` to `hold_valid`: 1 cycle (registered).
- Flags assert on the edge after the causing event.
- Latency from `load` to the first bit is not fixed; it depends on `frame`, with a minimum of 2 edges (load in cycle L, frame in cycle L+1).

## Test plan
- **Single word:** load 40'h80_0000_0001, frame 3 cycles later → `sdout` = 1, then 38 zeros, then 1 over 40 cycles; `out_ready` high for exactly 40 cycles; `hold_valid` 1→0 on the transfer edge.
- **Back-to-back:**
  - load A=40'hAAAAAAAAAA;
  - frame;
  - load B=40'h5555555555 during the shift;
  - frame at cycle E+40;
  - → 80 contiguous bits A then B, `out_ready` never drops, all flags 0.
- **Overrun/underrun:**
  - two loads (X, then Y) with no frame, then frame → Y is transmitted and `overrun`=1;
  - a further frame with nothing held → `underrun`=1, `out_ready` stays 0.
- **Mid-word frame:** frame at cycle E+10 of a word → current word completes unchanged (40 bits), `frame_err`=1, no extra word sent.
- **Simultaneous load+frame:** `hold_valid`=1 (word P); load Q in the same cycle as frame → P is sent, Q is held (`hold_valid`=1), `overrun`=0.
- **Async reset mid-word:** assert `clear_n`=0 between edges at bit 20 → `sdout`, `out_ready` and all flags are 0 immediately; after release, a new load+frame transmits correctly from the MSB.
